exibidor_sequencia: RTL and testbench
=====================================

# exibidor_sequencia

Sequence presenter for the memory game: on request it reads stored elements from the sequence memory at addresses 0..limite and shows each one on the LEDs for a fixed time, with an optional dark gap, then signals completion. It is the output side of the game's player interface: it drives the lights the player will later reproduce through the jogada/compare control unit. It sits beside that control unit, sharing the sequence memory address bus under top-level arbitration.

## Interface
- TEMPO_ACESO, default 1000: cycles each element stays lit; legal range ≥1.
- TEMPO_APAGADO, default 250: cycles of dark gap after each element; legal range ≥1; used only with gap feature.
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- iniciar  input  1  start request; sampled only in state ocioso.
- limite  input  4  index of last element to show (shows limite+1 elements).
- dado  input  4  memory read data for `endereco`; combinational read, valid in the same cycle.
- endereco  output  4  registered memory address.
- leds  output  4  registered LED pattern (one-hot element in the codebase's memory format).
- mostrando  output  1  high in every state except ocioso and fim.
- fim_mostra  output  1  one-cycle completion pulse.
- db_estado  output  4  current state code.

## Operation
- States (db_estado): ocioso 0, carrega 1, acende 2, apaga 3, proximo 4, fim F; illegal encoding → ocioso next cycle, db_estado F.
- ocioso: iniciar=1 → carrega; clear endereco, timer; latch limite into internal lim_r. Else stay.
- carrega (1 cycle): latch dado into leds register on exit; → acende.
- acende: leds = latched value; timer counts 0..TEMPO_ACESO-1; at TEMPO_ACESO-1 clear timer, → apaga.
- apaga: leds = 0; timer counts 0..TEMPO_APAGADO-1; at last count: endereco==lim_r → fim, else → proximo.
- proximo (1 cycle): endereco ← endereco+1; → carrega.
- fim (1 cycle): fim_mostra=1, leds=0; → ocioso. endereco holds last value until next start.
- Timer width $clog2(max(TEMPO_ACESO,TEMPO_APAGADO)+1); no wrap within legal params.
- iniciar outside ocioso ignored; limite changes after start ignored (lim_r used).
- limite=15: addresses 0..15 shown; endereco never increments past 15 (exit at 15 → fim).

## Timing
- Reset: state ocioso, endereco 0, leds 0, mostrando 0, fim_mostra 0, timer 0, lim_r 0, db_estado 0. Reset mid-display aborts immediately on that edge; no fim_mostra.
- Edge e0 samples iniciar=1 → carrega after e0; mostrando high from e0.
- Per-element duration D = 1 + TEMPO_ACESO + TEMPO_APAGADO cycles; proximo adds 1 between elements.
- fim entered after edge e0 + (L+1)·D + L, L = lim_r; fim_mostra high exactly that one cycle; ocioso next.
- leds go nonzero exactly at edge leaving carrega; go 0 at edge entering apaga.
- iniciar held high continuously: new run starts the cycle after fim (back-to-back, ocioso lasts one cycle).

## Configuration
- EXIBIDOR_GAP_EN defined: behaviour above, apaga state present.
- Not defined: apaga never entered; acende at last count goes directly to fim/proximo with the same endereco==lim_r test; D = 1 + TEMPO_ACESO; TEMPO_APAGADO unused; db_estado 3 never appears; consecutive equal elements show as continuous light except the 2 cycles (proximo, carrega) in which leds hold previous value.

## Test plan
- Reset then iniciar=1 one cycle, limite=1, TEMPO_ACESO=3, TEMPO_APAGADO=2, memory {0:0001,1:0100} (GAP_EN) -> leds 0001 for 3 cycles, 0 for 2, proximo, 0100 for 3, 0 for 2; fim_mostra single pulse after edge e13; endereco 0 then 1.
- Same stimulus, limite changed to 7 during display -> still only 2 elements, fim at e13.
- limite=15, A=1, G=1 -> endereco 0..15, no wrap, fim after e0+16·3+15=e63, then ocioso.
- Reset asserted during acende of element 1 -> next cycle state ocioso, leds 0, endereco 0, mostrando 0, no fim_mostra.
- iniciar pulsed during acende -> ignored, timing unchanged; iniciar held high -> second run's carrega immediately after ocioso following fim.
- Without EXIBIDOR_GAP_EN, limite=1, A=3 -> fim after e0+2·4+1=e9; db_estado never 3.

Source files
------------

// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia
// Sequence presenter for the memory game. On a start request it walks the
// sequence memory from address 0 up to the latched limit, shows each stored
// element on the LEDs for TEMPO_ACESO cycles, optionally followed by a dark
// gap of TEMPO_APAGADO cycles, and then pulses fim_mostra for one cycle.
//
// Build option:
//   EXIBIDOR_GAP_EN - when defined, the dark-gap state (apaga) is built in.
//                     When undefined, acende goes straight to proximo/fim and
//                     state code 3 is treated as an illegal encoding.
`timescale 1ns/1ps

module exibidor_sequencia #(
    parameter int TEMPO_ACESO   = 1000,
    parameter int TEMPO_APAGADO = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       mostrando,
    output logic       fim_mostra,
    output logic [3:0] db_estado
);

    // ------------------------------------------------------------------
    // Timer sizing: wide enough for the longer of the two phases, so the
    // terminal count of either phase is always representable.
    // ------------------------------------------------------------------
    localparam int TMAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

    localparam logic [TW-1:0] ACESO_LAST = TW'(TEMPO_ACESO - 1);
`ifdef EXIBIDOR_GAP_EN
    localparam logic [TW-1:0] APAGADO_LAST = TW'(TEMPO_APAGADO - 1);
`endif

    // ------------------------------------------------------------------
    // State encoding (codes are exported on db_estado as-is).
    // ------------------------------------------------------------------
    localparam logic [3:0] ST_OCIOSO  = 4'h0;
    localparam logic [3:0] ST_CARREGA = 4'h1;
    localparam logic [3:0] ST_ACENDE  = 4'h2;
    localparam logic [3:0] ST_APAGA   = 4'h3;
    localparam logic [3:0] ST_PROXIMO = 4'h4;
    localparam logic [3:0] ST_FIM     = 4'hF;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]    estado_q,   estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [3:0]    leds_q,     leds_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [3:0]    lim_q,      lim_d;

    // Terminal-count and last-element flags shared by the phase states.
    logic fim_aceso;
    logic ultimo;

    assign fim_aceso = (timer_q == ACESO_LAST);
    assign ultimo    = (endereco_q == lim_q);

`ifdef EXIBIDOR_GAP_EN
    logic fim_apagado;
    assign fim_apagado = (timer_q == APAGADO_LAST);
`endif

    // Next-state and datapath update for the presentation sequence.
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        leds_d     = leds_q;
        timer_d    = timer_q;
        lim_d      = lim_q;

        case (estado_q)
            ST_OCIOSO: begin
                // The limit is captured here so later changes on limite
                // cannot stretch or cut a run already in progress.
                if (iniciar) begin
                    estado_d   = ST_CARREGA;
                    endereco_d = 4'd0;
                    timer_d    = '0;
                    lim_d      = limite;
                end
            end

            ST_CARREGA: begin
                // Memory read is combinational, so dado already belongs to
                // the current endereco; latch it as the LED pattern.
                leds_d   = dado;
                timer_d  = '0;
                estado_d = ST_ACENDE;
            end

            ST_ACENDE: begin
                if (fim_aceso) begin
                    timer_d = '0;
`ifdef EXIBIDOR_GAP_EN
                    leds_d   = 4'd0;
                    estado_d = ST_APAGA;
`else
                    // No gap: the LEDs keep the element through proximo and
                    // carrega, so equal neighbours look like one long light.
                    if (ultimo) begin
                        leds_d   = 4'd0;
                        estado_d = ST_FIM;
                    end else begin
                        estado_d = ST_PROXIMO;
                    end
`endif
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

`ifdef EXIBIDOR_GAP_EN
            ST_APAGA: begin
                if (fim_apagado) begin
                    timer_d  = '0;
                    // Leaving on the limit (rather than after incrementing)
                    // keeps endereco from ever wrapping when the limit is 15.
                    estado_d = ultimo ? ST_FIM : ST_PROXIMO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif

            ST_PROXIMO: begin
                endereco_d = endereco_q + 4'd1;
                estado_d   = ST_CARREGA;
            end

            ST_FIM: begin
                // endereco is left on the last element until the next start.
                leds_d   = 4'd0;
                timer_d  = '0;
                estado_d = ST_OCIOSO;
            end

            default: begin
                // Illegal encoding: recover to idle with the lights off.
                leds_d   = 4'd0;
                timer_d  = '0;
                estado_d = ST_OCIOSO;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= ST_OCIOSO;
            endereco_q <= 4'd0;
            leds_q     <= 4'd0;
            timer_q    <= '0;
            lim_q      <= 4'd0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            timer_q    <= timer_d;
            lim_q      <= lim_d;
        end
    end

    // Status decode: mostrando covers the active display states only, and
    // any encoding outside the legal set reads back as F on db_estado.
    always_comb begin
        mostrando  = 1'b0;
        fim_mostra = 1'b0;
        db_estado  = 4'hF;
        case (estado_q)
            ST_OCIOSO: begin
                db_estado = ST_OCIOSO;
            end
            ST_CARREGA: begin
                db_estado = ST_CARREGA;
                mostrando = 1'b1;
            end
            ST_ACENDE: begin
                db_estado = ST_ACENDE;
                mostrando = 1'b1;
            end
`ifdef EXIBIDOR_GAP_EN
            ST_APAGA: begin
                db_estado = ST_APAGA;
                mostrando = 1'b1;
            end
`endif
            ST_PROXIMO: begin
                db_estado = ST_PROXIMO;
                mostrando = 1'b1;
            end
            ST_FIM: begin
                db_estado  = ST_FIM;
                fim_mostra = 1'b1;
            end
            default: begin
                db_estado = 4'hF;
            end
        endcase
    end

    assign endereco = endereco_q;
    assign leds     = leds_q;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia with TEMPO_ACESO=3, TEMPO_APAGADO=2.
// Expected timings are hand-derived for both builds (gap on / gap off).
`timescale 1ns/1ps

module tb_exibidor_sequencia;

`ifdef EXIBIDOR_GAP_EN
  localparam int D = 6;   // 1 + 3 + 2 cycles per element
`else
  localparam int D = 4;   // 1 + 3 cycles per element
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       mostrando;
  logic       fim_mostra;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  assign dado = mem[endereco];

  exibidor_sequencia #(.TEMPO_ACESO(3), .TEMPO_APAGADO(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .limite    (limite),
    .dado      (dado),
    .endereco  (endereco),
    .leds      (leds),
    .mostrando (mostrando),
    .fim_mostra(fim_mostra),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int fim_cnt = 0;
  bit seen3   = 1'b0;

  // Sampled on the rising edge, before the DUT registers update.
  always @(posedge clock) begin
    if (fim_mostra) fim_cnt <= fim_cnt + 1;
    if (db_estado == 4'd3) seen3 <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  // Present iniciar so the next rising edge is e0; afterwards cyc==k means
  // "sampled after edge ek".
  task automatic start(input logic [3:0] lim, input bit hold);
    limite  = lim;
    iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cyc = 0;
    if (!hold) iniciar = 1'b0;
  endtask

  task automatic exp_at(input int k, input logic [3:0] db, input logic [3:0] ld,
                        input logic [3:0] en, input logic mo, input logic fm);
    goto(k);
    chk($sformatf("db@e%0d", k),   db_estado,  db);
    chk($sformatf("leds@e%0d", k), leds,       ld);
    chk($sformatf("end@e%0d", k),  endereco,   en);
    chk($sformatf("most@e%0d", k), mostrando,  mo);
    chk($sformatf("fim@e%0d", k),  fim_mostra, fm);
  endtask

  // Two-element run (limite=1); optionally perturb iniciar/limite mid-run.
  task automatic run_short(input bit perturb);
    int f0;
    f0 = fim_cnt;
    start(4'd1, 1'b0);
    exp_at(0, 4'h1, 4'h0, 4'd0, 1'b1, 1'b0);
    exp_at(1, 4'h2, 4'h1, 4'd0, 1'b1, 1'b0);
    if (perturb) begin
      goto(2);
      iniciar = 1'b1;
      limite  = 4'd7;
      goto(3);
      iniciar = 1'b0;
    end
`ifdef EXIBIDOR_GAP_EN
    exp_at(3,  4'h2, 4'h1, 4'd0, 1'b1, 1'b0);
    exp_at(4,  4'h3, 4'h0, 4'd0, 1'b1, 1'b0);
    exp_at(5,  4'h3, 4'h0, 4'd0, 1'b1, 1'b0);
    exp_at(6,  4'h4, 4'h0, 4'd0, 1'b1, 1'b0);
    exp_at(7,  4'h1, 4'h0, 4'd1, 1'b1, 1'b0);
    exp_at(8,  4'h2, 4'h4, 4'd1, 1'b1, 1'b0);
    exp_at(10, 4'h2, 4'h4, 4'd1, 1'b1, 1'b0);
    exp_at(11, 4'h3, 4'h0, 4'd1, 1'b1, 1'b0);
    exp_at(12, 4'h3, 4'h0, 4'd1, 1'b1, 1'b0);
    exp_at(13, 4'hF, 4'h0, 4'd1, 1'b0, 1'b1);
    exp_at(14, 4'h0, 4'h0, 4'd1, 1'b0, 1'b0);
`else
    exp_at(3,  4'h2, 4'h1, 4'd0, 1'b1, 1'b0);
    exp_at(4,  4'h4, 4'h1, 4'd0, 1'b1, 1'b0);
    exp_at(5,  4'h1, 4'h1, 4'd1, 1'b1, 1'b0);
    exp_at(6,  4'h2, 4'h4, 4'd1, 1'b1, 1'b0);
    exp_at(8,  4'h2, 4'h4, 4'd1, 1'b1, 1'b0);
    exp_at(9,  4'hF, 4'h0, 4'd1, 1'b0, 1'b1);
    exp_at(10, 4'h0, 4'h0, 4'd1, 1'b0, 1'b0);
`endif
    chk("fim_pulses", fim_cnt - f0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  f0;
    bit  done;

    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    mem[0] = 4'b0001;
    mem[1] = 4'b0100;

    reset   = 1'b1;
    iniciar = 1'b0;
    limite  = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_db",   db_estado,  4'h0);
    chk("rst_end",  endereco,   4'd0);
    chk("rst_leds", leds,       4'd0);
    chk("rst_most", mostrando,  1'b0);
    chk("rst_fim",  fim_mostra, 1'b0);

    // Basic two-element run, then the same with mid-run disturbances.
    run_short(1'b0);
    run_short(1'b1);

    // Full-range run: limite=15 walks 0..15 and stops without wrapping.
    for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
    start(4'd15, 1'b0);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (db_estado == 4'h1) begin
        chk($sformatf("seq_end%0d", n), endereco, n);
        n++;
      end
      if (fim_mostra) done = 1'b1;
      else step();
    end
    chk("long_fim_seen", done, 1'b1);
    chk("long_fim_edge", cyc, 16 * D + 15);
    chk("long_end_last", endereco, 4'd15);
    chk("long_n_elem", n, 16);
    step();
    chk("long_idle", db_estado, 4'h0);

    // Reset while element 1 is lit aborts immediately, no completion pulse.
    mem[0] = 4'b0001;
    mem[1] = 4'b0100;
    f0 = fim_cnt;
    start(4'd1, 1'b0);
`ifdef EXIBIDOR_GAP_EN
    goto(9);
`else
    goto(7);
`endif
    chk("pre_rst_leds", leds, 4'b0100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_db",   db_estado,  4'h0);
    chk("mid_rst_leds", leds,       4'd0);
    chk("mid_rst_end",  endereco,   4'd0);
    chk("mid_rst_most", mostrando,  1'b0);
    chk("mid_rst_fim",  fim_mostra, 1'b0);
    repeat (20) step();
    chk("mid_rst_nofim", fim_cnt - f0, 0);
    chk("mid_rst_stay",  db_estado, 4'h0);

    // iniciar held high: back-to-back runs with one idle cycle between.
    mem[0] = 4'b1000;
    start(4'd0, 1'b1);
    exp_at(1,     4'h2, 4'b1000, 4'd0, 1'b1, 1'b0);
    exp_at(D,     4'hF, 4'h0,    4'd0, 1'b0, 1'b1);
    exp_at(D + 1, 4'h0, 4'h0,    4'd0, 1'b0, 1'b0);
    exp_at(D + 2, 4'h1, 4'h0,    4'd0, 1'b1, 1'b0);
    iniciar = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (fim_mostra) done = 1'b1;
      else step();
    end
    chk("hold_second_fim", done, 1'b1);
    chk("hold_second_edge", cyc, 2 * D + 2);
    step();
    chk("hold_idle", db_estado, 4'h0);

`ifdef EXIBIDOR_GAP_EN
    chk("apaga_seen", seen3, 1'b1);
`else
    chk("apaga_never", seen3, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
